// File: rtl/video_tx_timing_gen.sv
// video_tx_timing_gen: HDMI TX sync/DE/FID timing with pixel request and
// return-data alignment through a configurable-depth delay line.
module video_tx_timing_gen #(
   parameter int PIPELINE_DEPTH = 2
) (
   input  logic        PCLK_i,
   input  logic        reset_n,
   input  logic [31:0] hv_out_config,
   input  logic [31:0] hv_out_config2,
   input  logic [31:0] hv_out_config3,
   input  logic        vsync_lock_i,
   input  logic [7:0]  R_i,
   input  logic [7:0]  G_i,
   input  logic [7:0]  B_i,
   output logic [7:0]  R_o,
   output logic [7:0]  G_o,
   output logic [7:0]  B_o,
   output logic        HSYNC_o,
   output logic        VSYNC_o,
   output logic        DE_o,
   output logic        FID_o,
   output logic        de_req_o,
   output logic [10:0] xpos_o,
   output logic [10:0] ypos_o,
   output logic        sof_o
);
   localparam int LAST = PIPELINE_DEPTH - 1;
   logic [11:0] h_total, h_active, h_synclen, h_bp, v_total, v_active, v_synclen, v_bp, v_sof;
   logic [11:0] h_cnt, v_cnt, v_len, h_half, h_start, v_start;
   logic [12:0] h_end, v_end;
   logic        interlaced, fid, fid_out, even, h_deg, v_deg, h_wrap, v_wrap;
   logic        vs_even_low, hs, vs, de, sof;
   logic [3:0]  dly [PIPELINE_DEPTH];
   logic        unused_cfg;
   assign h_total    = hv_out_config[11:0];
   assign h_active   = hv_out_config[23:12];
   assign h_synclen  = {4'd0, hv_out_config[31:24]};
   assign h_bp       = {3'd0, hv_out_config2[8:0]};
   assign v_total    = {1'b0, hv_out_config2[19:9]};
   assign v_active   = {1'b0, hv_out_config2[30:20]};
   assign interlaced = hv_out_config2[31];
   assign v_synclen  = {8'd0, hv_out_config3[3:0]};
   assign v_bp       = {3'd0, hv_out_config3[12:4]};
   assign v_sof      = {1'b0, hv_out_config3[23:13]};
   assign unused_cfg = ^hv_out_config3[31:24];
   always_comb begin
      h_deg       = h_total < 12'd2;
      v_deg       = v_total < 12'd2;
      h_wrap      = h_deg || h_cnt >= h_total - 12'd1;
      v_len       = !interlaced ? v_total : fid ? (v_total + 12'd1) >> 1 : v_total >> 1;
      v_wrap      = v_deg || v_cnt >= v_len - 12'd1;
      h_half      = h_total >> 1;
      h_start     = h_synclen + h_bp;
      v_start     = v_synclen + v_bp;
      h_end       = {1'b0, h_start} + {1'b0, h_active};
      v_end       = {1'b0, v_start} + {1'b0, v_active};
      even        = interlaced && !fid;
      // even-field vsync spans half-line to half-line so the sink can tell field order
      vs_even_low = (v_cnt < v_synclen && (v_cnt != 12'd0 || h_cnt >= h_half)) ||
                    (v_cnt == v_synclen && v_synclen != 12'd0 && h_cnt < h_half);
      hs          = h_cnt >= h_synclen;
      vs          = even ? !vs_even_low : v_cnt >= v_synclen;
      de          = !h_deg && !v_deg && h_cnt >= h_start && {1'b0, h_cnt} < h_end &&
                    v_cnt >= v_start && {1'b0, v_cnt} < v_end;
      fid_out     = !interlaced || fid;
      sof         = !h_deg && h_cnt == 12'd0 && v_cnt == v_sof && fid_out;
   end
   assign de_req_o = de;
   assign xpos_o   = de ? h_cnt[10:0] - h_start[10:0] : 11'd0;
   assign ypos_o   = de ? v_cnt[10:0] - v_start[10:0] : 11'd0;
   always_ff @(posedge PCLK_i or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
         fid   <= 1'b1;
      end else if (vsync_lock_i) begin
         h_cnt <= '0;
         v_cnt <= '0;
         fid   <= 1'b1;
      end else if (h_wrap) begin
         h_cnt <= '0;
         if (!h_deg && v_wrap) begin
            v_cnt <= '0;
            fid   <= interlaced && !v_deg ? !fid : 1'b1;
         end else if (!h_deg) begin
            v_cnt <= v_cnt + 12'd1;
         end
      end else begin
         h_cnt <= h_cnt + 12'd1;
      end
   end
   // delay line entries are {hs, vs, de, fid}; idle = syncs high, DE low, odd field
   always_ff @(posedge PCLK_i or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < PIPELINE_DEPTH; i++) dly[i] <= 4'b1101;
         {HSYNC_o, VSYNC_o, DE_o, FID_o} <= 4'b1101;
         R_o   <= '0;
         G_o   <= '0;
         B_o   <= '0;
         sof_o <= 1'b0;
      end else begin
         dly[0] <= {hs, vs, de, fid_out};
         for (int i = 1; i < PIPELINE_DEPTH; i++) dly[i] <= dly[i-1];
         {HSYNC_o, VSYNC_o, DE_o, FID_o} <= dly[LAST];
         R_o   <= dly[LAST][1] ? R_i : 8'd0;
         G_o   <= dly[LAST][1] ? G_i : 8'd0;
         B_o   <= dly[LAST][1] ? B_i : 8'd0;
         sof_o <= sof;
      end
   end
endmodule

// File: tb/tb_video_tx_timing_gen.sv
// tb_video_tx_timing_gen: directed checks of timing, pixel alignment, lock,
// reset, config shrink, interlace and degenerate configs on small rasters.
module tb_video_tx_timing_gen;
   logic        PCLK_i = 1'b0, reset_n = 1'b0, vsync_lock_i = 1'b0;
   logic [31:0] cfg1, cfg2, cfg3;
   logic [7:0]  R_i, G_i, B_i, R_o, G_o, B_o;
   logic        HSYNC_o, VSYNC_o, DE_o, FID_o, de_req_o, sof_o;
   logic [10:0] xpos_o, ypos_o;
   logic [7:0]  r_d1 = 8'd0, r_d2 = 8'd0, g_d1 = 8'd0, g_d2 = 8'd0;
   int          total = 0, bad = 0;

   video_tx_timing_gen #(.PIPELINE_DEPTH(2)) dut (
      .PCLK_i(PCLK_i), .reset_n(reset_n), .hv_out_config(cfg1), .hv_out_config2(cfg2),
      .hv_out_config3(cfg3), .vsync_lock_i(vsync_lock_i), .R_i(R_i), .G_i(G_i), .B_i(B_i),
      .R_o(R_o), .G_o(G_o), .B_o(B_o), .HSYNC_o(HSYNC_o), .VSYNC_o(VSYNC_o), .DE_o(DE_o),
      .FID_o(FID_o), .de_req_o(de_req_o), .xpos_o(xpos_o), .ypos_o(ypos_o), .sof_o(sof_o));

   always #5 PCLK_i = ~PCLK_i;

   // upstream model: returns {xpos, ypos} two cycles after the request
   always @(posedge PCLK_i) begin
      r_d1 <= xpos_o[7:0];
      r_d2 <= r_d1;
      g_d1 <= ypos_o[7:0];
      g_d2 <= g_d1;
   end
   assign R_i = r_d2;
   assign G_i = g_d2;
   assign B_i = 8'hA5;

   function automatic logic [31:0] mk1(input int ht, input int ha, input int hsl);
      return {hsl[7:0], ha[11:0], ht[11:0]};
   endfunction
   function automatic logic [31:0] mk2(input int il, input int va, input int vt, input int hbp);
      return {il[0], va[10:0], vt[10:0], hbp[8:0]};
   endfunction
   function automatic logic [31:0] mk3(input int vsl, input int vbp, input int sofl);
      return {8'd0, sofl[10:0], vbp[8:0], vsl[3:0]};
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge PCLK_i);
   endtask

   initial begin
      int de_n, hs_n, vs_n, sof_n, sof_k, first_de, r_first, g_first, r_err, fid0_n, req_n, exp_x;
      // progressive 20x12 raster: h_start 5, 8 active; v_start 3, 5 active; sof line 4
      cfg1 = mk1(20, 8, 3);
      cfg2 = mk2(0, 5, 12, 2);
      cfg3 = mk3(2, 1, 4);
      repeat (3) tick();
      chk("rst_hsync", HSYNC_o, 1);
      chk("rst_vsync", VSYNC_o, 1);
      chk("rst_de", DE_o, 0);
      chk("rst_fid", FID_o, 1);
      chk("rst_r", R_o, 0);
      chk("rst_sof", sof_o, 0);
      chk("rst_xpos", xpos_o, 0);
      chk("rst_dereq", de_req_o, 0);
      reset_n = 1'b1;
      de_n = 0; hs_n = 0; vs_n = 0; sof_n = 0; sof_k = -1; first_de = -1;
      r_first = -1; g_first = -1; r_err = 0; fid0_n = 0; req_n = 0; exp_x = 0;
      for (int k = 1; k <= 240; k++) begin
         tick();
         if (DE_o) begin
            if (first_de < 0) begin
               first_de = k;
               r_first  = R_o;
               g_first  = G_o;
            end
            if (R_o !== exp_x[7:0] || B_o !== 8'hA5) r_err++;
            exp_x++;
            de_n++;
         end else begin
            exp_x = 0;
            if ((R_o | G_o | B_o) !== 8'd0) r_err++;
         end
         if (!HSYNC_o) hs_n++;
         if (!VSYNC_o) vs_n++;
         if (!FID_o) fid0_n++;
         if (de_req_o) req_n++;
         if (sof_o) begin
            sof_n++;
            if (sof_k < 0) sof_k = k;
         end
      end
      chk("first_de_cycle", first_de, 68);
      chk("first_de_r", r_first, 0);
      chk("first_de_g", g_first, 0);
      chk("de_count", de_n, 40);
      chk("pixel_align_errs", r_err, 0);
      chk("hsync_low", hs_n, 36);
      chk("vsync_low", vs_n, 40);
      chk("dereq_count", req_n, 40);
      chk("sof_count", sof_n, 1);
      chk("sof_cycle", sof_k, 81);
      chk("prog_fid0", fid0_n, 0);
      // lock pulse at h=10, v=5 (cycle 350)
      repeat (110) tick();
      vsync_lock_i = 1'b1;
      tick();
      vsync_lock_i = 1'b0;
      repeat (2) tick();
      chk("lock_drain_de", DE_o, 1);
      chk("lock_drain_r", R_o, 5);
      chk("lock_drain_hs", HSYNC_o, 1);
      tick();
      chk("lock_hsync", HSYNC_o, 0);
      chk("lock_vsync", VSYNC_o, 0);
      chk("lock_de", DE_o, 0);
      repeat (68) tick();
      chk("pre_rst_de", DE_o, 1);
      chk("pre_rst_r", R_o, 3);
      reset_n = 1'b0;
      #1;
      chk("midrst_hsync", HSYNC_o, 1);
      chk("midrst_vsync", VSYNC_o, 1);
      chk("midrst_de", DE_o, 0);
      chk("midrst_r", R_o, 0);
      tick();
      reset_n = 1'b1;
      tick();
      chk("resume_de_k1", DE_o, 0);
      tick();
      chk("resume_hs_k2", HSYNC_o, 1);
      tick();
      chk("resume_hs_k3", HSYNC_o, 0);
      // shrink H_TOTAL to 10 while h=15
      repeat (12) tick();
      cfg1 = mk1(10, 8, 3);
      repeat (3) tick();
      chk("shrink_hs_k18", HSYNC_o, 1);
      tick();
      chk("shrink_hs_k19", HSYNC_o, 0);
      repeat (3) tick();
      chk("shrink_hs_k22", HSYNC_o, 1);
      repeat (6) tick();
      chk("shrink_hs_k28", HSYNC_o, 1);
      tick();
      chk("shrink_hs_k29", HSYNC_o, 0);
      // interlaced: V_TOTAL 11 -> odd field 6 lines, even field 5 lines
      reset_n = 1'b0;
      cfg1 = mk1(20, 8, 3);
      cfg2 = mk2(1, 2, 11, 2);
      cfg3 = mk3(2, 1, 4);
      repeat (2) tick();
      reset_n = 1'b1;
      vs_n = 0; fid0_n = 0; de_n = 0; sof_n = 0;
      for (int k = 1; k <= 222; k++) begin
         tick();
         if (!VSYNC_o) vs_n++;
         if (!FID_o) fid0_n++;
         if (DE_o) de_n++;
         if (sof_o) sof_n++;
         if (k == 3) chk("il_odd_vs_fall", VSYNC_o, 0);
         if (k == 122) chk("il_fid_odd_end", FID_o, 1);
         if (k == 123) chk("il_fid_even", FID_o, 0);
         if (k == 132) chk("il_even_vs_pre", VSYNC_o, 1);
         if (k == 133) chk("il_even_vs_fall", VSYNC_o, 0);
      end
      chk("il_vsync_low", vs_n, 80);
      chk("il_fid0_count", fid0_n, 100);
      chk("il_de_count", de_n, 32);
      chk("il_sof_count", sof_n, 1);
      tick();
      chk("il_fid_odd_again", FID_o, 1);
      chk("il_vs_odd_again", VSYNC_o, 0);
      // degenerate H_TOTAL=1, then recovery
      reset_n = 1'b0;
      cfg1 = mk1(1, 8, 3);
      cfg2 = mk2(0, 5, 12, 2);
      repeat (2) tick();
      reset_n = 1'b1;
      de_n = 0; hs_n = 0;
      for (int k = 1; k <= 50; k++) begin
         tick();
         if (DE_o) de_n++;
         if (k >= 3 && HSYNC_o) hs_n++;
      end
      chk("degen_de", de_n, 0);
      chk("degen_hs_static", hs_n, 0);
      cfg1 = mk1(20, 8, 3);
      de_n = 0;
      for (int k = 1; k <= 243; k++) begin
         tick();
         if (DE_o) de_n++;
      end
      chk("recover_de", de_n, 40);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/video_tx_timing_gen.md
Name: video_tx_timing_gen

Overview:
- Output-side counterpart of the HDMI receiver frontend: generates HDMI-transmitter-facing video timing (HSYNC/VSYNC/DE/FID) from packed config words.
- Issues pixel coordinates to the upstream scaler/line buffer and re-aligns the returned RGB with delayed sync/DE, so the transmitter sees matched pixel and timing.
- Sits between the scaler output and the TX chip's parallel RGB bus.
- Supports progressive and interlaced modes, plus an external frame-lock restart.

Parameters:
- PIPELINE_DEPTH, 2: cycles from xpos_o/ypos_o/de_req_o to valid R_i/G_i/B_i; legal range 1..8.

Ports:
- PCLK_i  in  1  pixel clock
- reset_n  in  1  async active-low reset
- hv_out_config  in  32  [11:0] H_TOTAL, [23:12] H_ACTIVE, [31:24] H_SYNCLEN
- hv_out_config2  in  32  [8:0] H_BACKPORCH, [19:9] V_TOTAL, [30:20] V_ACTIVE, [31] INTERLACED
- hv_out_config3  in  32  [3:0] V_SYNCLEN, [12:4] V_BACKPORCH, [23:13] V_SOF_LINE
- vsync_lock_i  in  1  single-cycle pulse; restart frame
- R_i, G_i, B_i  in  8 each  pixel data returned PIPELINE_DEPTH cycles after request
- R_o, G_o, B_o  out  8 each  pixel data to TX; forced 0 when DE_o=0
- HSYNC_o, VSYNC_o  out  1  active-low syncs
- DE_o  out  1  data enable
- FID_o  out  1  field id, 1=odd/top, 0=even
- de_req_o  out  1  pixel request (undelayed DE)
- xpos_o  out  11  requested pixel column
- ypos_o  out  11  requested active line (field-relative)
- sof_o  out  1  one-cycle pulse at start of line V_SOF_LINE

Behaviour:
- Reset values: HSYNC_o=1, VSYNC_o=1, DE_o=0, de_req_o=0, R/G/B_o=0, FID_o=1, xpos_o=0, ypos_o=0, sof_o=0. Internal counters h_cnt=0, v_cnt=0, delay line cleared to the idle value (syncs 1, DE 0).
- h_cnt (12b) counts 0..H_TOTAL-1. Wrap when h_cnt >= H_TOTAL-1; the >= protects against H_TOTAL shrinking mid-line. On wrap, v_cnt increments.
- Progressive (INTERLACED=0): v_cnt counts 0..V_TOTAL-1, wrap uses the same >= rule. FID_o stays 1.
- Interlaced field lengths: odd field (FID=1) has (V_TOTAL+1)>>1 lines; even field (FID=0) has V_TOTAL>>1 lines. FID toggles when v_cnt wraps.
- Interlaced VSYNC timing:
  - Odd field: VSYNC falls at h_cnt=0 of v_cnt=0.
  - Even field: VSYNC falls at h_cnt=H_TOTAL>>1 of v_cnt=0 and rises at h_cnt=H_TOTAL>>1 of v_cnt=V_SYNCLEN.
  - This half-line offset is what the receiver uses to detect field order.
- Stage-0 timing, combinational from the counters and registered one cycle:
  - hs = ~(h_cnt < H_SYNCLEN).
  - vs = ~(v_cnt < V_SYNCLEN); apply the half-line rule above in even fields.
  - de = (h_cnt in [H_SYNCLEN+H_BACKPORCH, +H_ACTIVE)) AND (v_cnt in [V_SYNCLEN+V_BACKPORCH, +V_ACTIVE)).
- Arithmetic: all sums are computed 12b unsigned, without truncation.
- Request stage: de_req_o=de, xpos_o=h_cnt-H_SYNCLEN-H_BACKPORCH, ypos_o=v_cnt-V_SYNCLEN-V_BACKPORCH (low 11 bits). xpos/ypos are don't-care when de_req_o=0.
- Alignment: hs, vs, de and fid pass through a PIPELINE_DEPTH-deep shift register. HSYNC_o/VSYNC_o/DE_o/FID_o are registered at the same cycle that R_i/G_i/B_i are sampled to R/G/B_o, giving total latency from counter to output = PIPELINE_DEPTH+1.
- sof_o: pulses for one cycle when h_cnt=0 and v_cnt=V_SOF_LINE, in odd fields only when interlaced.
- vsync_lock_i:
  - Next cycle: h_cnt=0, v_cnt=0, FID internal=1.
  - The delay line is not flushed; in-flight outputs drain normally.
  - A lock pulse coinciding with a natural wrap has the same result.
- Degenerate config: H_TOTAL or V_TOTAL < 2 holds the corresponding counter at 0. Outputs stay static with DE=0, and there is no lockup.
- Config words may change at any time. Effects take place within one line/frame with no illegal counter state.

Test Plan:
- 720x480p (H_TOTAL 858, H_ACTIVE 720, HSYNC 62, HBP 60, V_TOTAL 525, V_ACTIVE 480, VSYNC 6, VBP 30), PIPELINE_DEPTH=2:
  - First DE_o rises at h_cnt=122+3 on v_cnt=36.
  - 720 DE cycles per line; 480 active lines.
  - HSYNC_o low 62 cycles; VSYNC_o low 6 lines; frame period 450450 cycles.
- Pixel alignment: return R_i=xpos[7:0] from a 2-cycle model -> R_o on the first DE_o cycle = 0, incrementing each cycle; R_o=0 outside DE.
- Interlaced 1080i (H_TOTAL 2200, V_TOTAL 1125):
  - Odd field 563 lines, even field 562 lines.
  - Even-field VSYNC_o falls 1100 cycles after HSYNC_o falls; FID_o alternates 1,0.
- vsync_lock_i pulsed mid-line (v_cnt=200, h_cnt=400) -> next cycle counters restart; after 3 cycles HSYNC_o=0 and VSYNC_o=0.
- Assert reset_n low mid-active-line -> outputs immediately at reset values (HSYNC_o=1, DE_o=0, R_o=0). Resume at h_cnt=0 after release.
- Shrink H_TOTAL from 858 to 100 while h_cnt=500 -> wrap on next cycle, then 100-cycle lines. sof_o pulses once per frame at V_SOF_LINE=10.
